mem_port_arbiter: RTL and testbench

- Shares the single-port RAM between two requesters: port 0 (CPU control unit's MAR/MDR path) and port 1 (input-port loader / debug DMA).
- Grants one whole transaction at a time with fair round-robin arbitration.
- Drives the RAM address, data and write strobe, and returns read data after a fixed RAM latency.
- Sits between the requesters and the RAM; the CPU FSM waits on done0 instead of assuming fixed memory timing.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// It runs one whole transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
module mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [2:0] LAT = 3'(READ_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_gnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        wait_cnt;
    logic              any_req;
    logic              pick;

    // Under contention the port that did not win last time goes next.
    always_comb begin
        any_req = req0 | req1;
        pick    = (req0 && req1) ? ~last_gnt : req1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? DONE : WAIT;
            WAIT:    if (wait_cnt == 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (any_req) begin
                    owner     <= pick;
                    last_gnt  <= pick;
                    lat_we    <= pick ? we1 : we0;
                    lat_addr  <= pick ? addr1 : addr0;
                    lat_wdata <= pick ? wdata1 : wdata0;
                end
                ISSUE: wait_cnt <= LAT;
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) rdata <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

    // Pulses decode straight from state so an async reset kills them at once.
    always_comb begin
        gnt0      = (state == ISSUE) && !owner;
        gnt1      = (state == ISSUE) &&  owner;
        done0     = (state == DONE)  && !owner;
        done1     = (state == DONE)  &&  owner;
        ram_write = (state == ISSUE) && lat_we;
        busy      = (state != IDLE);
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: transaction table on a READ_LAT=1 instance, hand sequences
// for contention, reset abort and a READ_LAT=3 read on a second instance.
module tb_mem_port_arbiter;

    logic        Clock, Reset;
    logic        req0, we0, req1, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, done0, gnt1, done1, ram_write, busy, owner;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;

    logic        req0_3, we0_3, req1_3, we1_3;
    logic [8:0]  addr0_3, addr1_3;
    logic [31:0] wdata0_3, wdata1_3;
    logic        gnt0_3, done0_3, gnt1_3, done1_3, ram_write_3, busy_3, owner_3;
    logic [31:0] rdata_3, ram_wdata_3, ram_rdata_3;
    logic [8:0]  ram_addr_3;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) u1 (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner));

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3)) u3 (
        .Clock(Clock), .Reset(Reset),
        .req0(req0_3), .we0(we0_3), .addr0(addr0_3), .wdata0(wdata0_3), .gnt0(gnt0_3), .done0(done0_3),
        .req1(req1_3), .we1(we1_3), .addr1(addr1_3), .wdata1(wdata1_3), .gnt1(gnt1_3), .done1(done1_3),
        .rdata(rdata_3), .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3), .ram_write(ram_write_3),
        .ram_rdata(ram_rdata_3), .busy(busy_3), .owner(owner_3));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [31:0] mem1 [512];
    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 512; i++) mem1[i] <= '0;
        end else if (ram_write) begin
            mem1[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem1[ram_addr];
    end

    always @(posedge Clock)
        ram_rdata_3 <= (ram_addr_3 == 9'h1FF) ? 32'hCAFEF00D : 32'h0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // One isolated transaction on the READ_LAT=1 instance, started from IDLE.
    task automatic run_txn(input vec_t v);
        int due;
        due = v.we ? 2 : 3;
        if (!v.port) begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        else         begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        tick();
        chk("gnt_own",   v.port ? gnt1 : gnt0, 1);
        chk("gnt_other", v.port ? gnt0 : gnt1, 0);
        chk("issue_we",  ram_write, v.we);
        chk("issue_addr", ram_addr, v.addr);
        if (v.we) chk("issue_wdata", ram_wdata, v.wdata);
        chk("owner", owner, v.port);
        req0 = 0; req1 = 0;
        for (int c = 2; c <= due; c++) begin
            tick();
            chk("no_write", ram_write, 0);
            chk("done_own",   v.port ? done1 : done0, (c == due));
            chk("done_other", v.port ? done0 : done1, 0);
        end
        chk("rdata", rdata, v.exp_rdata);
        tick();
        chk("idle", busy, 0);
    endtask

    task automatic pulse_reset();
        Reset = 1;
        tick();
        Reset = 0;
        tick();
    endtask

    int n_gnt;
    int viol;
    logic order [3];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 9'h000, 32'h0,        32'hA5A5A5A5};

        Reset = 1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        req0_3 = 0; we0_3 = 0; addr0_3 = '0; wdata0_3 = '0;
        req1_3 = 0; we1_3 = 0; addr1_3 = '0; wdata1_3 = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1, ram_write}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        Reset = 0;
        tick();

        // READ_LAT=3 read of 0x1FF on the second instance
        req0_3 = 1; addr0_3 = 9'h1FF;
        tick();
        chk("l3_gnt", gnt0_3, 1);
        req0_3 = 0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("l3_wait_busy", busy_3, 1);
            chk("l3_wait_done", done0_3, 0);
            chk("l3_wait_we", ram_write_3, 0);
            chk("l3_wait_addr", ram_addr_3, 9'h1FF);
            chk("l3_wait_rdata", rdata_3, 0);
        end
        tick();
        chk("l3_done", done0_3, 1);
        chk("l3_rdata", rdata_3, 32'hCAFEF00D);
        tick();
        chk("l3_idle", busy_3, 0);
        chk("l3_hold", rdata_3, 32'hCAFEF00D);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Both ports hold write requests: expect grants 0,1,0
        pulse_reset();
        req0 = 1; we0 = 1; addr0 = 9'h010; wdata0 = 32'h11111111;
        req1 = 1; we1 = 1; addr1 = 9'h020; wdata1 = 32'h22222222;
        n_gnt = 0; viol = 0;
        for (int cyc = 0; cyc < 40 && n_gnt < 3; cyc++) begin
            tick();
            if (gnt0 && gnt1) viol++;
            if (done0 && done1) viol++;
            if (gnt0 || gnt1) begin
                order[n_gnt] = gnt1;
                chk("rr_owner", owner, gnt1);
                n_gnt++;
            end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            tick();
            if (gnt0 && gnt1) viol++;
            if (done0 && done1) viol++;
        end
        chk("rr_count", n_gnt, 3);
        chk("rr_order0", order[0], 0);
        chk("rr_order1", order[1], 1);
        chk("rr_order2", order[2], 0);
        chk("rr_mutex", viol, 0);
        chk("rr_idle", busy, 0);

        // Port 1 read aborted by reset during WAIT
        req1 = 1; we1 = 0; addr1 = 9'h010;
        tick();
        req1 = 0;
        tick();
        chk("ab_in_wait", busy, 1);
        #2 Reset = 1;
        #1;
        chk("ab_pulses", {gnt0, gnt1, done0, done1, ram_write}, 0);
        chk("ab_busy", busy, 0);
        chk("ab_owner", owner, 0);
        chk("ab_rdata", rdata, 0);
        chk("ab_addr", ram_addr, 0);
        tick();
        chk("ab_no_done", done1, 0);
        tick();
        Reset = 0;
        chk("ab_no_done2", done1, 0);
        tick();
        req0 = 1; we0 = 1; addr0 = 9'h030; wdata0 = 32'h33333333;
        req1 = 1; we1 = 1; addr1 = 9'h040; wdata1 = 32'h44444444;
        tick();
        chk("ab_first_gnt0", gnt0, 1);
        chk("ab_first_gnt1", gnt1, 0);
        req0 = 0;
        tick(); tick(); tick();
        chk("ab_second_gnt1", gnt1, 1);
        req1 = 0;
        tick(); tick();
        chk("ab_idle", busy, 0);

        // req1 held; port 0 arrives during port 1's DONE and must win next
        req1 = 1; we1 = 1; addr1 = 9'h050; wdata1 = 32'h55555555;
        tick();
        chk("sv_gnt1_a", gnt1, 1);
        tick();
        chk("sv_done1", done1, 1);
        req0 = 1; we0 = 1; addr0 = 9'h060; wdata0 = 32'h66666666;
        tick();
        chk("sv_idle_gap", busy, 0);
        tick();
        chk("sv_gnt0", gnt0, 1);
        chk("sv_not_gnt1", gnt1, 0);
        req0 = 0;
        tick();
        chk("sv_done0", done0, 1);
        tick(); tick();
        chk("sv_gnt1_b", gnt1, 1);
        chk("sv_mem", mem1[9'h060], 32'h66666666);
        req1 = 0;
        tick(); tick();
        chk("sv_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
